// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the pc_stack program counter.
//   pc_cmd_e    - resolved per-cycle command after priority arbitration.
//   pc_resolve  - maps the raw decoder strobes onto a single pc_cmd_e.
//   PC_WIDTH_DEF / PC_DEPTH_DEF - default address width and stack depth.
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEF = 16;
  localparam int unsigned PC_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_INC  = 3'd1,
    CMD_REL  = 3'd2,
    CMD_LOAD = 3'd3,
    CMD_CALL = 3'd4,
    CMD_RET  = 3'd5
  } pc_cmd_e;

  // Priority: ret > call > load > rel > inc > hold. Reset is handled by the
  // register itself. When rel_en is clear a lone rel falls through to inc/hold.
  function automatic pc_cmd_e pc_resolve(
    input logic inc,
    input logic rel,
    input logic load,
    input logic call,
    input logic ret,
    input logic rel_en
  );
    pc_cmd_e cmd;
    if (ret)                 cmd = CMD_RET;
    else if (call)           cmd = CMD_CALL;
    else if (load)           cmd = CMD_LOAD;
    else if (rel && rel_en)  cmd = CMD_REL;
    else if (inc)            cmd = CMD_INC;
    else                     cmd = CMD_HOLD;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_lifo.sv
// pc_lifo: DEPTH-entry return-address stack for pc_stack.
//   clk      - rising-edge clock
//   reset    - synchronous active-low; clears the entry count only
//   push_i   - write wdata_i on top (ignored when full)
//   pop_i    - drop the top entry (ignored when empty)
//   wdata_i  - address to push
//   rdata_o  - current top entry (don't-care when empty)
//   full_o   - count == DEPTH
//   empty_o  - count == 0
module pc_lifo #(
  parameter int unsigned WIDTH = pc_pkg::PC_WIDTH_DEF,
  parameter int unsigned DEPTH = pc_pkg::PC_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  // count is at most DEPTH, so its low bits address the next free slot;
  // the top entry sits one below.
  assign wr_idx  = cnt_q[AW-1:0];
  assign top_idx = AW'(cnt_q - CW'(1));
  assign rdata_o = mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Storage is not reset: entries above count are never observed.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem_q[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with return-address stack and sticky stack errors.
//   clk, reset        - rising-edge clock, synchronous active-low reset
//   in                - absolute target for load / call
//   offset            - two's-complement displacement for rel
//   inc/load/rel/call/ret - decoder strobes (ret > call > load > rel > inc)
//   err_clr           - clears ovf/udf (a same-cycle set wins)
//   out               - registered PC
//   stack_full/empty  - decoded from the registered stack count
//   ovf / udf         - sticky call-on-full / ret-on-empty flags
// Build option: define PC_STACK_REL_EN to enable the rel command; otherwise
// rel and offset are ignored and the offset adder is not built.
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned      DEPTH     = PC_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] offset,
  input  logic             inc,
  input  logic             load,
  input  logic             rel,
  input  logic             call,
  input  logic             ret,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             ovf,
  output logic             udf
);

`ifdef PC_STACK_REL_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  pc_cmd_e          cmd;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] top_addr;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             push;
  logic             pop;
  logic             set_ovf;
  logic             set_udf;

  assign cmd      = pc_resolve(inc, rel, load, call, ret, REL_EN);
  assign pc_plus1 = pc_q + WIDTH'(1);

  assign set_ovf = (cmd == CMD_CALL) && stack_full;
  assign set_udf = (cmd == CMD_RET) && stack_empty;
  assign push    = (cmd == CMD_CALL) && !stack_full;
  assign pop     = (cmd == CMD_RET) && !stack_empty;

`ifdef PC_STACK_REL_EN
  logic [WIDTH-1:0] pc_rel;
  assign pc_rel = pc_q + offset;
`else
  logic unused_offset;
  assign unused_offset = ^offset;
`endif

  pc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pc_plus1),
    .rdata_o (top_addr),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (cmd)
      CMD_INC:  pc_d = pc_plus1;
`ifdef PC_STACK_REL_EN
      CMD_REL:  pc_d = pc_rel;
`endif
      CMD_LOAD: pc_d = in;
      // A call on a full stack still jumps; only the push is lost.
      CMD_CALL: pc_d = in;
      CMD_RET:  pc_d = stack_empty ? pc_q : top_addr;
      default:  pc_d = pc_q;
    endcase
  end

  // Clear first, then OR in this cycle's event so a same-edge set wins.
  always_comb begin
    ovf_d = (ovf_q && !err_clr) || set_ovf;
    udf_d = (udf_q && !err_clr) || set_udf;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign out = pc_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

  localparam int unsigned W = 16;
  localparam int unsigned D = 8;
  localparam logic [W-1:0] RV = 16'h0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din, doff;
  logic         inc, load, rel, call, ret, err_clr;
  logic [W-1:0] out;
  logic         stack_full, stack_empty, ovf, udf;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          chk_en = 1'b0;

  // Reference model: PC value, stack as a queue (back = top), sticky flags.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_ovf, m_udf;

  pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(RV)) dut (
    .clk(clk), .reset(reset), .in(din), .offset(doff),
    .inc(inc), .load(load), .rel(rel), .call(call), .ret(ret),
    .err_clr(err_clr), .out(out), .stack_full(stack_full),
    .stack_empty(stack_empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit s_ovf, s_udf;
    s_ovf = 1'b0;
    s_udf = 1'b0;
    if (!reset) begin
      m_pc = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (ret) begin
        if (m_stk.size() == 0) s_udf = 1'b1;
        else m_pc = m_stk.pop_back();
      end else if (call) begin
        if (m_stk.size() < D) m_stk.push_back(m_pc + 16'd1);
        else s_ovf = 1'b1;
        m_pc = din;
      end else if (load) begin
        m_pc = din;
`ifdef PC_STACK_REL_EN
      end else if (rel) begin
        m_pc = m_pc + doff;
`endif
      end else if (inc) begin
        m_pc = m_pc + 16'd1;
      end
      if (err_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      m_ovf = m_ovf | s_ovf;
      m_udf = m_udf | s_udf;
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", out, m_pc);
      chk("stack_full", W'(stack_full), W'(m_stk.size() == D));
      chk("stack_empty", W'(stack_empty), W'(m_stk.size() == 0));
      chk("ovf", W'(ovf), W'(m_ovf));
      chk("udf", W'(udf), W'(m_udf));
    end
  end

  // Drive one cycle of inputs (called just after a negedge), then advance.
  task automatic cyc(input logic r, input logic i_inc, input logic i_load,
                     input logic i_rel, input logic i_call, input logic i_ret,
                     input logic i_clr, input logic [W-1:0] i_in,
                     input logic [W-1:0] i_off);
    reset = r; inc = i_inc; load = i_load; rel = i_rel; call = i_call;
    ret = i_ret; err_clr = i_clr; din = i_in; doff = i_off;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    cyc(1, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    logic [W-1:0] exp_ret;
    reset = 1'b0; inc = 0; load = 0; rel = 0; call = 0; ret = 0; err_clr = 0;
    din = '0; doff = '0;
    @(negedge clk);

    cyc(0, 0, 0, 0, 0, 0, 0, '0, '0);
    chk("lit_reset_out", out, 16'h0000);
    chk("lit_reset_empty", W'(stack_empty), 16'd1);

    for (int i = 1; i <= 3; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, '0, '0);
      chk("lit_inc", out, W'(i));
    end
    cyc(1, 0, 1, 0, 0, 0, 0, 16'hFFFF, '0);
    chk("lit_load", out, 16'hFFFF);
    cyc(1, 1, 0, 0, 0, 0, 0, '0, '0);
    chk("lit_wrap", out, 16'h0000);

    cyc(1, 0, 1, 0, 0, 0, 0, 16'h0100, '0);
    cyc(1, 0, 0, 1, 0, 0, 0, '0, 16'hFFFE);
`ifdef PC_STACK_REL_EN
    chk("lit_rel", out, 16'h00FE);
`else
    chk("lit_rel", out, 16'h0100);
`endif

    cyc(1, 0, 1, 0, 0, 0, 0, 16'h0010, '0);
    cyc(1, 0, 0, 0, 1, 0, 0, 16'h0200, '0);
    chk("lit_call_out", out, 16'h0200);
    chk("lit_call_empty", W'(stack_empty), 16'd0);
    cyc(1, 0, 0, 0, 0, 1, 0, '0, '0);
    chk("lit_ret_out", out, 16'h0011);
    chk("lit_ret_empty", W'(stack_empty), 16'd1);

    // Nine calls from 0x0500: the ninth overflows.
    cyc(1, 0, 1, 0, 0, 0, 0, 16'h0500, '0);
    for (int k = 0; k < 9; k++) begin
      cyc(1, 0, 0, 0, 1, 0, 0, 16'h1000 + W'(16 * k), '0);
      if (k == 7) chk("lit_full", W'(stack_full), 16'd1);
    end
    chk("lit_ovf", W'(ovf), 16'd1);
    chk("lit_ovf_out", out, 16'h1080);
    for (int j = 0; j < 8; j++) begin
      cyc(1, 0, 0, 0, 0, 1, 0, '0, '0);
      exp_ret = (j == 7) ? 16'h0501 : 16'h1000 + W'(16 * (6 - j)) + 16'd1;
      chk("lit_lifo", out, exp_ret);
    end
    cyc(1, 0, 0, 0, 0, 0, 1, '0, '0);
    chk("lit_ovf_clr", W'(ovf), 16'd0);

    cyc(1, 0, 0, 0, 0, 1, 0, '0, '0);
    chk("lit_udf", W'(udf), 16'd1);
    chk("lit_udf_out", out, 16'h0501);
    cyc(1, 0, 0, 0, 0, 0, 1, '0, '0);
    chk("lit_udf_clr", W'(udf), 16'd0);

    cyc(1, 1, 1, 0, 1, 0, 0, 16'h0300, '0);
    chk("lit_prio_out", out, 16'h0300);
    chk("lit_prio_empty", W'(stack_empty), 16'd0);

    cyc(0, 0, 0, 0, 1, 0, 0, 16'h0777, '0);
    chk("lit_rst_out", out, RV);
    chk("lit_rst_empty", W'(stack_empty), 16'd1);
    cyc(1, 0, 0, 0, 0, 1, 0, '0, '0);
    chk("lit_rst_udf", W'(udf), 16'd1);

    // Randomised traffic, call-heavy phases alternate with ret-heavy ones.
    for (int n = 0; n < 3000; n++) begin
      int unsigned bias;
      bias = ((n / 200) % 2 == 0) ? 40 : 15;
      cyc(($urandom_range(99) >= 2),
          ($urandom_range(99) < 30), ($urandom_range(99) < 15),
          ($urandom_range(99) < 25), ($urandom_range(99) < bias),
          ($urandom_range(99) < 55 - bias), ($urandom_range(99) < 10),
          W'($urandom), W'($urandom));
    end
    idle_in();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with a hardware return-address stack, the next-generation PC for the team's CPU datapath. It keeps the existing increment / absolute-load / reset behaviour and adds PC-relative branches, subroutine call and return through a DEPTH-entry LIFO, and sticky stack-error flags. It sits between the instruction decoder, which issues one-hot-or-idle commands each cycle, and the instruction-memory address port.

## Interface
- WIDTH, 16: address width in bits.
- DEPTH, 8: return-stack entries; a power of two, at least 2.
- RESET_VEC, 0: value of `out` after reset; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous and active-low; clears state on the clk edge where `reset`=0.
- in  input  WIDTH  absolute target for load and call.
- offset  input  WIDTH  two's-complement displacement for rel.
- inc  input  1  advance PC by 1.
- load  input  1  PC <= in.
- rel  input  1  PC <= out + offset.
- call  input  1  push out+1, then PC <= in.
- ret  input  1  PC <= popped stack entry.
- err_clr  input  1  clears the sticky error flags.
- out  output  WIDTH  current PC; registered.
- stack_full  output  1  count == DEPTH.
- stack_empty  output  1  count == 0.
- ovf  output  1  sticky: a call was issued while the stack was full.
- udf  output  1  sticky: a ret was issued while the stack was empty.

## Operation
- Reset values: out=RESET_VEC, count=0, stack_empty=1, stack_full=0, ovf=0, udf=0. Stack contents are don't-care.
- Command priority when several inputs are high in one cycle: reset > ret > call > load > rel > inc > hold. Only the winning command takes effect. Lower-priority commands are dropped and have no side effects.
- inc: out <= out+1, modulo 2^WIDTH (all-ones wraps to 0).
- rel: out <= out+offset, modulo 2^WIDTH, with the carry discarded. Example for WIDTH=16: offset=16'hFFFE moves the PC back by 2.
- call, stack not full: push out+1, count+1, out <= in.
- call, stack full: out <= in; the push is discarded; count and contents are unchanged; ovf <= 1.
- ret, stack not empty: out <= top entry, count-1.
- ret, stack empty: out holds; count stays 0; udf <= 1.
- err_clr: clears ovf and udf on the same edge. If the same cycle sets a flag, the set wins, so the flag stays 1.
- Hold (no command): all state is unchanged.

## Timing
- Single clock domain. All state updates on the rising clk edge.
- One-cycle latency: a command sampled at edge N is visible on `out` after edge N.
- stack_full and stack_empty are decoded combinationally from the registered count, so they reflect the post-edge count in the same cycle as `out`.
- Back-to-back calls and rets are legal on every cycle, with no bubbles.
- reset=0 overrides all commands in that cycle, including a call or ret in progress. Pending stack contents are abandoned.
- There are no handshakes; the decoder guarantees commands are stable around the edge.

## Configuration
- PC_STACK_REL_EN defined: the rel command operates as specified.
- PC_STACK_REL_EN undefined:
  - The rel and offset ports remain present but are ignored.
  - A cycle with only rel asserted is a hold.
  - The offset adder is not built.

## Structure
- Package pc_pkg holds:
  - a typedef enum of the resolved command (CMD_HOLD, CMD_INC, CMD_REL, CMD_LOAD, CMD_CALL, CMD_RET);
  - the priority-resolve function;
  - the default WIDTH/DEPTH constants.
- Sub-module pc_lifo(WIDTH, DEPTH):
  - synchronous push/pop storage, count register and full/empty decode;
  - same clk and reset, with reset clearing count only.
- The top level holds command resolution, the PC register, the next-PC mux and the sticky flags.

## Test plan
- Reset, then 3 incs: out = 0,1,2,3. Then load in=16'hFFFF, then inc: out = FFFF, then 0000 (wrap).
- out=16'h0100 with rel offset=16'hFFFE: out=16'h00FE. Rebuilt without PC_STACK_REL_EN: out holds at 16'h0100.
- out=16'h0010, call in=16'h0200: out=0200, stack_empty=0. Then ret: out=0011, stack_empty=1.
- DEPTH=8 with 9 consecutive calls:
  - stack_full=1 after the 8th call;
  - ovf=1 after the 9th call, with out equal to the 9th call's in;
  - 8 rets then return the correct addresses in LIFO order.
- ret while empty: udf=1, out unchanged. Then err_clr: udf=0. Simultaneous call+load+inc: only the call executes.
- Mid-sequence reset=0 with call asserted: out=RESET_VEC, count=0, flags cleared. The next ret sets udf.
